// File: rtl/factorizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : factorizer_pkg
// Description : Shared types and constants for the trial-division factorizer.
// Revision    : 1.0 - initial release
// ============================================================================
package factorizer_pkg;

   // Default operand / factor width of the engine.
   localparam int DEFAULT_WIDTH = 8;

   // Trial divisors run 2, 3, 5, 7, ... : the first odd divisor follows 2.
   localparam int FIRST_ODD_DIVISOR = 3;

   // Control states of the factorizer.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHECK     = 3'd1,
      DIV       = 3'd2,
      EMIT      = 3'd3,
      EMIT_LAST = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring unsigned divider, one quotient bit per cycle.
//               Produces quot/rem WIDTH cycles after start, with a
//               one-cycle done pulse. The divisor must be held stable while
//               a division is running.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
   import factorizer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             running;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quot;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   trial_sub;

   // Partial remainder shifted left by one, pulling in the next dividend bit.
   always_comb begin
      trial     = {rem, quot[WIDTH-1]};
      trial_sub = trial - {1'b0, divisor_i};
   end

   // Iterate one restoring step per cycle; the quotient register doubles as
   // the dividend shift register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         running <= 1'b0;
         count   <= '0;
         rem     <= '0;
         quot    <= '0;
         done_o  <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (start_i) begin
            running <= 1'b1;
            count   <= CNT_W'(WIDTH - 1);
            rem     <= '0;
            quot    <= dividend_i;
         end else if (running) begin
            if (trial >= {1'b0, divisor_i}) begin
               rem  <= trial_sub[WIDTH-1:0];
               quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
               rem  <= trial[WIDTH-1:0];
               quot <= {quot[WIDTH-2:0], 1'b0};
            end
            if (count == '0) begin
               running <= 1'b0;
               done_o  <= 1'b1;
            end else begin
               count <= count - 1'b1;
            end
         end
      end
   end

   assign quot_o = quot;
   assign rem_o  = rem;

endmodule
`default_nettype wire

// File: rtl/trial_factorizer.sv
`default_nettype none
// ============================================================================
// Module      : trial_factorizer
// Description : Prime factorisation by trial division. Streams the prime
//               factors of value_i in ascending order (with multiplicity)
//               over a valid/ready interface; the last factor is flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module trial_factorizer
   import factorizer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] value_i,
   output logic             busy_o,
   output logic             fac_valid_o,
   input  logic             fac_ready_i,
   output logic [WIDTH-1:0] fac_data_o,
   output logic             fac_last_o
);

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   n;
   logic [WIDTH-1:0]   n_next;
   logic [WIDTH-1:0]   d;
   logic [WIDTH-1:0]   d_next;
   logic [WIDTH-1:0]   data;
   logic [WIDTH-1:0]   data_next;
   logic               div_start;
   logic               div_done;
   logic [WIDTH-1:0]   div_quot;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] d_sq;

   // Full-width square so the d*d > n test never wraps.
   assign d_sq = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};

   seq_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (n),
      .divisor_i  (d),
      .done_o     (div_done),
      .quot_o     (div_quot),
      .rem_o      (div_rem)
   );

   // Next-state and datapath updates for the trial-division loop.
   always_comb begin
      state_next = state;
      n_next     = n;
      d_next     = d;
      data_next  = data;
      div_start  = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               n_next = value_i;
               d_next = WIDTH'(2);
               if (value_i < WIDTH'(2)) begin
                  data_next  = value_i;
                  state_next = EMIT_LAST;
               end else begin
                  state_next = CHECK;
               end
            end
         end
         CHECK: begin
            // Once d exceeds sqrt(n), whatever remains of n is prime.
            if (d_sq > {{WIDTH{1'b0}}, n}) begin
               data_next  = n;
               state_next = EMIT_LAST;
            end else begin
               div_start  = 1'b1;
               state_next = DIV;
            end
         end
         DIV: begin
            if (div_done) begin
               if (div_rem == '0) begin
                  data_next  = d;
                  n_next     = div_quot;
                  state_next = EMIT;
               end else begin
                  d_next     = (d == WIDTH'(2)) ? WIDTH'(FIRST_ODD_DIVISOR) : d + WIDTH'(2);
                  state_next = CHECK;
               end
            end
         end
         EMIT: begin
            if (fac_ready_i) state_next = CHECK;
         end
         EMIT_LAST: begin
            if (fac_ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, working operands and output data register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         n     <= '0;
         d     <= '0;
         data  <= '0;
      end else begin
         state <= state_next;
         n     <= n_next;
         d     <= d_next;
         data  <= data_next;
      end
   end

   // Outputs decode the registered state only; ready never reaches valid.
   assign busy_o      = (state != IDLE);
   assign fac_valid_o = (state == EMIT) || (state == EMIT_LAST);
   assign fac_last_o  = (state == EMIT_LAST);
   assign fac_data_o  = data;

endmodule
`default_nettype wire

// File: tb/tb_trial_factorizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trial_factorizer
// Description : Self-checking bench for trial_factorizer at WIDTH=8 and
//               WIDTH=16 against a plain trial-division reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trial_factorizer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ready = 1'b0;

   logic        start8 = 1'b0;
   logic [7:0]  val8 = '0;
   logic        busy8, valid8, last8;
   logic [7:0]  data8;

   logic        start16 = 1'b0;
   logic [15:0] val16 = '0;
   logic        busy16, valid16, last16;
   logic [15:0] data16;

   int checks = 0;
   int errors = 0;
   int ready_pct = 100;

   longint mq[$];
   longint exp8[$];
   longint exp16[$];
   longint job8 = 0, job16 = 0, prod8 = 1, prod16 = 1;

   trial_factorizer #(.WIDTH(8)) dut8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start8),
      .value_i     (val8),
      .busy_o      (busy8),
      .fac_valid_o (valid8),
      .fac_ready_i (ready),
      .fac_data_o  (data8),
      .fac_last_o  (last8)
   );

   trial_factorizer #(.WIDTH(16)) dut16 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start16),
      .value_i     (val16),
      .busy_o      (busy16),
      .fac_valid_o (valid16),
      .fac_ready_i (ready),
      .fac_data_o  (data16),
      .fac_last_o  (last16)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic check_s(input string name, input string act, input string expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %s, expected %s", name, act, expv);
      end
   endtask

   // Reference: ascending prime factors by plain trial division into mq.
   task automatic factorize(input longint v);
      longint x;
      x = v;
      mq.delete();
      if (v < 2) begin
         mq.push_back(v);
      end else begin
         for (longint p = 2; p * p <= x; p++) begin
            while (x % p == 0) begin
               mq.push_back(p);
               x = x / p;
            end
         end
         if (x > 1) mq.push_back(x);
      end
   endtask

   function automatic string fstr();
      string s;
      s = "";
      foreach (mq[i]) s = {s, (i == 0) ? "" : ",", $sformatf("%0d", mq[i])};
      return s;
   endfunction

   // Ready pattern: each cycle ready is high with probability ready_pct %.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   // Scoreboard for the 8-bit engine.
   bit pv8 = 0, pr8 = 0, pl8 = 0, idle8 = 0;
   logic [7:0] pd8 = '0;
   always @(negedge clk) begin
      longint e;
      if (!rst_n) begin
         exp8.delete();
         pv8 = 0;
         idle8 = 0;
      end else begin
         if (idle8) begin
            check("busy8_after_last", busy8, 0);
            idle8 = 0;
         end
         if (pv8 && !pr8) begin
            check("hold8_valid", valid8, 1);
            check("hold8_data", data8, pd8);
            check("hold8_last", last8, pl8);
         end
         if (valid8 && ready) begin
            check("beat8_expected", longint'(exp8.size() > 0), 1);
            if (exp8.size() > 0) begin
               e = exp8.pop_front();
               check("data8", data8, e);
               check("last8", last8, longint'(exp8.size() == 0));
               prod8 = prod8 * data8;
               if (last8) begin
                  check("product8", prod8, job8);
                  idle8 = 1;
               end
            end
         end
         pv8 = valid8; pr8 = ready; pd8 = data8; pl8 = last8;
      end
   end

   // Scoreboard for the 16-bit engine.
   bit pv16 = 0, pr16 = 0, pl16 = 0, idle16 = 0;
   logic [15:0] pd16 = '0;
   always @(negedge clk) begin
      longint e;
      if (!rst_n) begin
         exp16.delete();
         pv16 = 0;
         idle16 = 0;
      end else begin
         if (idle16) begin
            check("busy16_after_last", busy16, 0);
            idle16 = 0;
         end
         if (pv16 && !pr16) begin
            check("hold16_valid", valid16, 1);
            check("hold16_data", data16, pd16);
            check("hold16_last", last16, pl16);
         end
         if (valid16 && ready) begin
            check("beat16_expected", longint'(exp16.size() > 0), 1);
            if (exp16.size() > 0) begin
               e = exp16.pop_front();
               check("data16", data16, e);
               check("last16", last16, longint'(exp16.size() == 0));
               prod16 = prod16 * data16;
               if (last16) begin
                  check("product16", prod16, job16);
                  idle16 = 1;
               end
            end
         end
         pv16 = valid16; pr16 = ready; pd16 = data16; pl16 = last16;
      end
   end

   // One job: load the model, pulse start, wait (bounded) for completion.
   // poke >= 0 pulses a stray start (value 4) that many cycles into the job.
   task automatic run(input bit wide, input longint v, input int poke);
      int n;
      string tag;
      n = 0;
      tag = wide ? "16" : "8";
      factorize(v);
      if (wide) begin
         foreach (mq[i]) exp16.push_back(mq[i]);
         job16 = v; prod16 = 1; val16 = v[15:0]; start16 = 1'b1;
      end else begin
         foreach (mq[i]) exp8.push_back(mq[i]);
         job8 = v; prod8 = 1; val8 = v[7:0]; start8 = 1'b1;
      end
      @(posedge clk); #1;
      start8 = 1'b0; start16 = 1'b0;
      check({"busy_capture", tag}, wide ? busy16 : busy8, 1);
      while ((wide ? busy16 : busy8) && n < 6000) begin
         if (!wide && n == poke) begin
            start8 = 1'b1; val8 = 8'd4;
         end else begin
            start8 = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start8 = 1'b0;
      check({"job_in_budget", tag}, wide ? busy16 : busy8, 0);
      check({"model_drained", tag}, wide ? exp16.size() : exp8.size(), 0);
   endtask

   initial begin
      int n;
      // Pin the reference model itself.
      factorize(12);    check_s("model_12", fstr(), "2,2,3");
      factorize(255);   check_s("model_255", fstr(), "3,5,17");
      factorize(128);   check_s("model_128", fstr(), "2,2,2,2,2,2,2");
      factorize(65535); check_s("model_65535", fstr(), "3,5,17,257");
      factorize(1);     check_s("model_1", fstr(), "1");

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy8", busy8, 0);   check("rst_valid8", valid8, 0);
      check("rst_data8", data8, 0);   check("rst_last8", last8, 0);
      check("rst_busy16", busy16, 0); check("rst_valid16", valid16, 0);
      check("rst_data16", data16, 0); check("rst_last16", last16, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      ready_pct = 100;
      run(0, 12, -1);
      run(0, 97, -1);
      run(0, 255, -1);
      run(0, 128, -1);
      run(0, 0, -1);
      run(0, 1, -1);
      run(0, 2, -1);
      ready_pct = 30;
      run(0, 60, -1);
      ready_pct = 100;
      run(0, 91, 4);
      run(1, 65521, -1);
      run(1, 65535, -1);

      // Reset while a beat is stalled on back-pressure.
      ready_pct = 0;
      @(posedge clk); #1;
      factorize(60);
      foreach (mq[i]) exp8.push_back(mq[i]);
      job8 = 60; prod8 = 1; val8 = 8'd60; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 0;
      while (!valid8 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("stall_valid8", valid8, 1);
      check("stall_data8", data8, 2);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_busy8", busy8, 0);   check("midrst_valid8", valid8, 0);
      check("midrst_data8", data8, 0);   check("midrst_last8", last8, 0);
      rst_n = 1'b1;
      ready_pct = 100;
      @(posedge clk); #1;
      run(0, 6, -1);

      // Randomised values with random back-pressure.
      ready_pct = 70;
      for (int i = 0; i < 460; i++) run(0, longint'($urandom_range(0, 255)), -1);
      for (int i = 0; i < 40; i++) run(1, longint'($urandom_range(0, 65535)), -1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
